shift_dist_unit: RTL
====================

// Module: shift_dist_unit
// PURPOSE
//  Multicycle shifter with built-in shift-distance source selection. Replaces the separate
//  distance-select mux + shift register pair in the datapath: on start, picks the distance
//  from one of N_SRC operand buses, captures the data word, shifts iteratively STEP bits
//  per cycle, then presents the result with a done pulse. Sits between the A/B/immediate
//  operand registers and the write-back mux; the control FSM waits on done.
// PARAMETERS
//  WIDTH    32              data and distance-source width
//  N_SRC    3               distance sources (0=B, 1=A, 2=imm15:0 sext<<2)
//  STEP     1               max bits shifted per cycle; power of 2, 1..WIDTH
//  SHAMT_W  $clog2(WIDTH)   distance bits used (derived, do not override)
//  SEL_W    $clog2(N_SRC)   selector width (derived; minimum 1)
// PORTS
//  clk       in   1              rising-edge clock
//  reset     in   1              asynchronous, active-low (asserted at 0)
//  start     in   1              request; sampled only in IDLE or DONE
//  dist_sel  in   SEL_W          distance source index
//  dist_src  in   N_SRC*WIDTH    flattened sources, src k = [k*WIDTH +: WIDTH]
//  op        in   3              000 pass, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR
//  data_in   in   WIDTH          word to shift
//  busy      out  1              1 in SHIFT state
//  done      out  1              1-cycle pulse; data_out valid from this cycle on
//  sel_err   out  1              registered; 1 if last accepted dist_sel >= N_SRC
//  data_out  out  WIDTH          result; held until next accepted start
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, done=0, sel_err=0, data_out=0, remaining=0.
//  States IDLE, SHIFT, DONE (encoding in package).
//  Accept: start=1 in IDLE or DONE -> latch data_in into the work register, latch op,
//    remaining = dist_src[dist_sel][SHAMT_W-1:0] (upper bits ignored), sel_err = (sel>=N_SRC).
//    Out-of-range sel: distance 0. Next state SHIFT if remaining!=0 and op!=pass, else DONE.
//  start in SHIFT is ignored (not queued); inputs are don't-care outside the accept cycle.
//  SHIFT: each cycle, k = min(STEP, remaining); shift work register by k per op;
//    remaining -= k; when the new remaining is 0 -> DONE.
//    SRA fills with the latched sign bit; SLL/SRL fill with 0; ROL/ROR wrap.
//    op 110/111: treated as pass.
//  DONE: done=1 for exactly this cycle, data_out <= work register, taken on entry to DONE.
//    Then IDLE, or SHIFT/DONE again on a start in the same cycle (back-to-back).
//  Latency: accept at edge 0 -> done high after ceil(shamt/STEP)+1 edges;
//    shamt 0 or pass -> done after 1 edge.
//  data_out changes only on entry to DONE; never glitches during SHIFT.
//  Reset mid-SHIFT: result discarded, no done pulse.
// STRUCTURE
//  Package shift_dist_pkg: state enum, op codes (OP_PASS..OP_ROR), clog2 helper.
//  Sub-module shift_step: combinational single-step shifter (work, op, k) -> next work,
//  k <= STEP. The top level holds the FSM, source selection, and registers.
// TESTING
//  1. WIDTH=32, STEP=1, sel=0, B=5, op=SLL, data=0x0000_0003 -> done at edge 6, out=0x0000_0060.
//  2. sel=1, A=0xFFFF_FFE4 (shamt=4), op=SRA, data=0x8000_0000 -> out=0xF800_0000, busy 4 cycles.
//  3. STEP=8, sel=2, imm=0x0000_001F, op=ROR, data=0x0000_0001 -> out=0x0000_0002, done at edge 5.
//  4. shamt=0, op=SRL, data=0x1234_5678 -> done at edge 1, out unchanged; sel=3 -> sel_err=1, out=data.
//  5. start during SHIFT ignored; start coincident with done -> second op accepted, no idle gap.
//  6. reset low mid-SHIFT -> busy/done/data_out=0 immediately; no done after release; next op correct.

Source files
------------

// File: rtl/shift_dist_pkg.sv
// Shared definitions for the multicycle shifter: FSM state codes, op codes and
// small helpers used to size and decode the datapath.
package shift_dist_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res++;
    end
    return res;
  endfunction

  // Codes 110/111 are reserved and behave like pass.
  function automatic logic op_is_pass(input logic [2:0] op);
    return (op == OP_PASS) || (op > OP_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves the work word by min(STEP, remaining)
// bits in the direction and fill mode selected by op.
module shift_step
  import shift_dist_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STEP    = 1,
  parameter int unsigned SHAMT_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   work_i,
  input  logic [2:0]         op_i,
  input  logic [SHAMT_W-1:0] rem_i,
  output logic [SHAMT_W-1:0] k_o,
  output logic [WIDTH-1:0]   work_o
);

  always_comb begin
    if (32'(rem_i) > STEP) begin
      k_o = SHAMT_W'(STEP);
    end else begin
      k_o = rem_i;
    end
  end

  // SRA keeps the MSB, which is the sign bit latched at accept time.
  always_comb begin
    work_o = work_i;
    case (op_i)
      OP_SLL:  work_o = work_i << k_o;
      OP_SRL:  work_o = work_i >> k_o;
      OP_SRA:  work_o = $signed(work_i) >>> k_o;
      OP_ROL:  work_o = (work_i << k_o) | (work_i >> (WIDTH - 32'(k_o)));
      OP_ROR:  work_o = (work_i >> k_o) | (work_i << (WIDTH - 32'(k_o)));
      default: work_o = work_i;
    endcase
  end

endmodule

// File: rtl/shift_dist_unit.sv
// Multicycle shifter with integrated distance-source selection. Accepts a request in
// IDLE or DONE, shifts up to STEP bits per cycle, then pulses done with the result.
module shift_dist_unit
  import shift_dist_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned N_SRC   = 3,
  parameter int unsigned STEP    = 1,
  parameter int unsigned SHAMT_W = clog2(WIDTH),
  parameter int unsigned SEL_W   = (N_SRC > 1) ? clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SEL_W-1:0]       dist_sel,
  input  logic [N_SRC*WIDTH-1:0] dist_src,
  input  logic [2:0]             op,
  input  logic [WIDTH-1:0]       data_in,
  output logic                   busy,
  output logic                   done,
  output logic                   sel_err,
  output logic [WIDTH-1:0]       data_out
);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [2:0]         op_q, op_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               sel_err_q, sel_err_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;

  logic [WIDTH-1:0]   src_word;
  logic [SHAMT_W-1:0] src_shamt;
  logic               sel_oob;
  logic               unused_src_hi;
  logic [WIDTH-1:0]   step_work;
  logic [SHAMT_W-1:0] step_k;

  always_comb begin
    src_word = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (32'(dist_sel) == k) begin
        src_word = dist_src[k*WIDTH +: WIDTH];
      end
    end
  end

  // An out-of-range selector yields distance 0 so the word passes through untouched.
  assign sel_oob       = (32'(dist_sel) >= N_SRC);
  assign src_shamt     = sel_oob ? '0 : src_word[SHAMT_W-1:0];
  assign unused_src_hi = ^src_word[WIDTH-1:SHAMT_W];

  shift_step #(
    .WIDTH   (WIDTH),
    .STEP    (STEP),
    .SHAMT_W (SHAMT_W)
  ) u_shift_step (
    .work_i (work_q),
    .op_i   (op_q),
    .rem_i  (rem_q),
    .k_o    (step_k),
    .work_o (step_work)
  );

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    op_d       = op_q;
    rem_d      = rem_q;
    sel_err_d  = sel_err_q;
    data_out_d = data_out_q;
    if (state_q == StShift) begin
      work_d = step_work;
      rem_d  = rem_q - step_k;
      if (rem_d == '0) begin
        state_d    = StDone;
        data_out_d = step_work;
      end
    end else if (start) begin
      work_d    = data_in;
      op_d      = op;
      rem_d     = src_shamt;
      sel_err_d = sel_oob;
      if ((src_shamt != '0) && !op_is_pass(op)) begin
        state_d = StShift;
      end else begin
        state_d    = StDone;
        data_out_d = data_in;
      end
    end else begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      work_q     <= '0;
      op_q       <= OP_PASS;
      rem_q      <= '0;
      sel_err_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      sel_err_q  <= sel_err_d;
      data_out_q <= data_out_d;
    end
  end

  assign busy     = (state_q == StShift);
  assign done     = (state_q == StDone);
  assign sel_err  = sel_err_q;
  assign data_out = data_out_q;

endmodule
